jk_flip_flop: RTL and testbench
===============================

// Module: jk_flip_flop
// PURPOSE
//   Positive-edge-triggered JK flip-flop: hold, reset, set or toggle, with a true and a complementary output.
//   Leaf storage primitive for counters, toggle dividers and small control FSMs in the digital-logic lab set.
//   Vectorised by WIDTH: each bit is an independent JK cell sharing clk and rst_n.
// PARAMETERS
//   WIDTH        1       number of independent JK cells (J, K, Q, Q_not are all WIDTH bits)
//   RESET_VALUE  {WIDTH{1'b0}}  value loaded into Q on reset
// PORTS
//   clk    input   1      clock; all state changes on rising edge only
//   rst_n  input   1      synchronous active-low reset
//   J      input   WIDTH  set request, per bit
//   K      input   WIDTH  reset request, per bit
//   Q      output  WIDTH  registered state
//   Q_not  output  WIDTH  bitwise complement of Q
//   Port declaration order is J, K, clk, Q, Q_not, rst_n, so positional instances of (J, K, clk, Q, Q_not) stay valid.
//   One clock (clk); reset rst_n is synchronous and active-low.
// BEHAVIOUR
//   - Reset:
//     - Sampled only at posedge clk. rst_n=0 at an edge -> Q=RESET_VALUE, Q_not=~RESET_VALUE.
//     - Reset has priority over J/K.
//     - Deasserting mid-operation takes effect at the next edge; no asynchronous path.
//   - Per bit i, at posedge clk with rst_n=1:
//     - J=0,K=0 -> Q[i] holds
//     - J=0,K=1 -> Q[i]=0
//     - J=1,K=0 -> Q[i]=1
//     - J=1,K=1 -> Q[i]=~Q[i] (toggles once per rising edge while both held high)
//   - Latency:
//     - One clock. New Q is visible right after the rising edge.
//     - J/K changes between edges have no effect; no level sensitivity, no race-through.
//   - Q_not:
//     - Derived combinationally from the Q register: Q_not == ~Q at all times, including during reset.
//     - Never a separately registered copy.
//   - Falling edge of clk: no state change.
//   - Power-up (before the first reset edge): Q undefined in simulation; the bench must apply reset before checking values.
//   - X/Z on J or K with rst_n=1: Q may go X in simulation; no recovery requirement other than reset.
//   - Bits are fully independent: toggle on bit 0 does not affect bit 1 for WIDTH>1.
// TESTING
//   - Clock period 20 ns.
//   - Sample Q/Q_not 1 ns after each rising edge.
//   - Check Q_not==~Q on every sample.
//   1. rst_n=0 for 2 edges, J=1,K=1 -> Q=0, Q_not=1 both edges (reset beats toggle).
//   2. After reset: J=0,K=1 edge -> Q=0; J=1,K=0 edge -> Q=1; J=0,K=0 for 3 edges -> Q stays 1, Q_not stays 0.
//   3. From Q=0, J=1,K=1 for 4 edges -> Q sequence 1,0,1,0; Q_not 0,1,0,1.
//   4. J/K glitch (J=1 pulse 3 ns wide) placed mid-low-phase between edges -> no change in Q.
//   5. Q=1, then rst_n low for 5 ns between edges with no edge inside -> Q stays 1; rst_n low across an edge -> Q=0 at that edge.
//   6. WIDTH=4, RESET_VALUE=4'b1010:
//      - reset -> Q=4'b1010.
//      - Then J=4'b0011, K=4'b0101 at one edge -> Q=4'b1011 (bit0 toggle 0->1, bit1 set, bit2 reset, bit3 hold).

Source files
------------

// File: rtl/jk_flip_flop.sv
// Vector of independent positive-edge JK flip-flops with a synchronous active-low reset.
// Each bit holds, resets, sets or toggles on the rising edge according to its own J/K pair.
// Q_not is the combinational complement of the state register, not a second flop.
module jk_flip_flop #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             clk,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_not,
    input  logic             rst_n
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Characteristic equation per bit: set when J and currently 0, keep 1 unless K.
    // Covers hold (00), reset (01), set (10) and toggle (11) in one expression.
    always_comb begin
        q_d = (J & ~q_q) | (~K & q_q);
    end

    // State register; reset is sampled only on the rising edge and beats J/K.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q     = q_q;
    assign Q_not = ~q_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed bench for jk_flip_flop: a 1-bit instance for the JK truth table, reset
// priority and glitch immunity, plus a 4-bit instance with a non-zero reset value.
module tb_jk_flip_flop;

    logic       clk;
    logic       rst_n;
    logic       j;
    logic       k;
    logic       q;
    logic       qn;

    logic       rst4_n;
    logic [3:0] j4;
    logic [3:0] k4;
    logic [3:0] q4;
    logic [3:0] qn4;

    int n_cmp;
    int n_bad;

    jk_flip_flop dut1 (
        .J    (j),
        .K    (k),
        .clk  (clk),
        .Q    (q),
        .Q_not(qn),
        .rst_n(rst_n)
    );

    jk_flip_flop #(
        .WIDTH      (4),
        .RESET_VALUE(4'b1010)
    ) dut4 (
        .J    (j4),
        .K    (k4),
        .clk  (clk),
        .Q    (q4),
        .Q_not(qn4),
        .rst_n(rst4_n)
    );

    // 20 ns period, rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check Q and Q_not of the 1-bit instance against the expected Q.
    task automatic chk1(input string tag, input logic exp);
        check({tag, ".q"}, {3'b000, q}, {3'b000, exp});
        check({tag, ".qn"}, {3'b000, qn}, {3'b000, ~exp});
    endtask

    initial begin
        logic [3:0] tog_seq;
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        j       = 1'b1;
        k       = 1'b1;
        rst4_n  = 1'b0;
        j4      = 4'b0000;
        k4      = 4'b0000;
        tog_seq = 4'b0101;

        // 1: reset beats toggle for two edges
        tick();
        chk1("rst_e1", 1'b0);
        tick();
        chk1("rst_e2", 1'b0);

        // 6: 4-bit instance reset value, then mixed hold/set/reset/toggle
        check("w4_rst.q", q4, 4'b1010);
        check("w4_rst.qn", qn4, 4'b0101);
        rst4_n = 1'b1;
        j4     = 4'b0011;
        k4     = 4'b0101;
        tick();
        check("w4_mix.q", q4, 4'b1011);
        check("w4_mix.qn", qn4, 4'b0100);
        j4 = 4'b0000;
        k4 = 4'b0000;
        tick();
        check("w4_hold.q", q4, 4'b1011);

        // 2: reset, set, hold
        rst_n = 1'b1;
        j     = 1'b0;
        k     = 1'b1;
        tick();
        chk1("k_only", 1'b0);
        j = 1'b1;
        k = 1'b0;
        tick();
        chk1("j_only", 1'b1);
        j = 1'b0;
        k = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1($sformatf("hold%0d", i), 1'b1);
        end

        // 3: toggle from 0 for four edges -> 1,0,1,0
        j = 1'b0;
        k = 1'b1;
        tick();
        chk1("pre_tog", 1'b0);
        j = 1'b1;
        k = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1($sformatf("tog%0d", i), tog_seq[i]);
        end

        // 4: 3 ns J pulse inside the low phase has no effect
        j = 1'b0;
        k = 1'b0;
        #13 j = 1'b1;
        #3 j = 1'b0;
        tick();
        chk1("glitch", 1'b0);

        // 5: short reset pulse between edges is ignored; reset across an edge clears
        j = 1'b1;
        k = 1'b0;
        tick();
        chk1("set_again", 1'b1);
        j = 1'b0;
        k = 1'b0;
        #13 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        tick();
        chk1("rst_between", 1'b1);
        rst_n = 1'b0;
        tick();
        chk1("rst_edge", 1'b0);
        rst_n = 1'b1;
        j     = 1'b1;
        k     = 1'b0;
        tick();
        chk1("post_rst_set", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
